// File: rtl/obi_data_bridge_if.sv
// OBI data-side bus between the core and the RAM/testbench bridge.
// The master drives the request; the slave answers with grant and response.
interface obi_data_bridge_if;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;

    modport master (
        output data_req_i,
        output data_addr_i,
        output data_we_i,
        output data_be_i,
        output data_wdata_i,
        input  data_gnt_o,
        input  data_rvalid_o,
        input  data_rdata_o
    );

    modport slave (
        input  data_req_i,
        input  data_addr_i,
        input  data_we_i,
        input  data_be_i,
        input  data_wdata_i,
        output data_gnt_o,
        output data_rvalid_o,
        output data_rdata_o
    );
endinterface

// File: rtl/obi_data_bridge.sv
// OBI data port to RAM port B bridge with optional LFSR grant stalls
// and decoding of the print and exit testbench registers.
module obi_data_bridge #(
    parameter int unsigned ADDR_WIDTH    = 22,
    parameter bit          STALL_EN      = 1'b0,
    parameter int unsigned MAX_GNT_STALL = 3,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter logic [31:0] PRINT_ADDR    = 32'h1000_0000,
    parameter logic [31:0] EXIT_ADDR     = 32'h2000_0004
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    obi_data_bridge_if.slave      bus,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i,
    output logic                  print_valid_o,
    output logic [7:0]            print_char_o,
    output logic                  exit_valid_o,
    output logic [31:0]           exit_value_o,
    output logic                  oob_o
);
    typedef enum logic [1:0] {
        IDLE,
        STALL,
        GRANT
    } state_t;

    localparam logic [1:0] MAX_S = 2'(MAX_GNT_STALL);

    state_t      state;
    logic [1:0]  cnt;
    logic [1:0]  draw;
    logic [15:0] lfsr;
    logic        gnt;
    logic        rd_sel;
    logic        is_print;
    logic        is_exit;
    logic        in_ram;
    logic        ram_acc;
    logic        is_oob;

    assign draw = !STALL_EN ? 2'd0 :
                  (lfsr[1:0] > MAX_S) ? MAX_S : lfsr[1:0];

    always_comb begin
        gnt = 1'b0;
        if (!rst_i) begin
            unique case (state)
                IDLE:    gnt = bus.data_req_i && (draw == 2'd0);
                GRANT:   gnt = bus.data_req_i;
                default: gnt = 1'b0;
            endcase
        end
    end

    // MMIO writes win over RAM; MMIO reads fall through to the zero response.
    assign is_print = bus.data_we_i && (bus.data_addr_i == PRINT_ADDR);
    assign is_exit  = bus.data_we_i && (bus.data_addr_i == EXIT_ADDR);
    assign in_ram   = (bus.data_addr_i >> ADDR_WIDTH) == 32'd0;
    assign ram_acc  = in_ram && !is_print && !is_exit;
    assign is_oob   = !in_ram &&
                      (bus.data_addr_i != PRINT_ADDR) &&
                      (bus.data_addr_i != EXIT_ADDR);

    assign ram_en_o    = gnt && ram_acc;
    assign ram_addr_o  = ram_en_o ? bus.data_addr_i[ADDR_WIDTH-1:0] : '0;
    assign ram_we_o    = ram_en_o && bus.data_we_i;
    assign ram_be_o    = ram_en_o ? bus.data_be_i : 4'h0;
    assign ram_wdata_o = ram_en_o ? bus.data_wdata_i : 32'h0;

    assign bus.data_gnt_o   = gnt;
    assign bus.data_rdata_o = rd_sel ? ram_rdata_i : 32'h0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= IDLE;
            cnt               <= 2'd0;
            lfsr              <= LFSR_SEED;
            bus.data_rvalid_o <= 1'b0;
            rd_sel            <= 1'b0;
            print_valid_o     <= 1'b0;
            print_char_o      <= 8'h0;
            exit_valid_o      <= 1'b0;
            exit_value_o      <= 32'h0;
            oob_o             <= 1'b0;
        end else begin
            lfsr <= {lfsr[14:0],
                     lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            bus.data_rvalid_o <= gnt;
            rd_sel            <= gnt && ram_acc && !bus.data_we_i;
            print_valid_o     <= gnt && is_print;
            if (gnt && is_print) begin
                print_char_o <= bus.data_wdata_i[7:0];
            end
            if (gnt && is_exit) begin
                exit_valid_o <= 1'b1;
                exit_value_o <= bus.data_wdata_i;
            end
            if (gnt && is_oob) begin
                oob_o <= 1'b1;
            end
            // Grant lands exactly draw cycles after the request is seen.
            unique case (state)
                IDLE: begin
                    if (bus.data_req_i && (draw != 2'd0)) begin
                        cnt   <= draw;
                        state <= (draw == 2'd1) ? GRANT : STALL;
                    end
                end
                STALL: begin
                    if (!bus.data_req_i) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 2'd1;
                        if (cnt == 2'd2) begin
                            state <= GRANT;
                        end
                    end
                end
                GRANT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
